kbd_lock_fsm: RTL and testbench
===============================

# kbd_lock_fsm

Parametrised keyboard modifier/lock state machine: generalises the single caps-lock toggle into N independent channels, each configured as toggle-lock, momentary (held) or one-shot (sticky) modifier. Sits between the PS/2 key decoder (which supplies per-channel make/break pulses) and the character-mapping and LED logic, which consume the per-channel modifier state. Suppresses typematic auto-repeat, so a held key never re-toggles, and reports every state change with a one-cycle pulse.

## Interface
- N_CH, 3, number of modifier channels (1..16)
- MODE_VEC, 6'b00_00_00, 2 bits per channel, channel i at [2i+1:2i]: 00 toggle, 01 momentary, 10 one-shot, 11 treated as toggle
- RESET_STATE, 3'b000, per-channel value of mode_out after reset and after clear

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- make  in  N_CH  per-channel key-press pulse, 1 cycle each; typematic repeats arrive as further make pulses without an intervening break
- brk  in  N_CH  per-channel key-release pulse, 1 cycle
- consume  in  1  pulse from the mapper: a non-modifier character was emitted this cycle
- clear  in  1  synchronous clear of all channels
- mode_out  out  N_CH  registered modifier state per channel
- held  out  N_CH  registered "key physically down" flag per channel
- change  out  N_CH  1-cycle pulse, bit i high in the cycle where mode_out[i] differs from its previous value
- any_change  out  1  OR of change

## Operation
- Per-channel state: mode bit (mode_out[i]) and held bit (held[i]). Channels are fully independent except through clear and consume.
- Held tracking: make sets held, brk clears held. A make while held=1 is a repeat and causes no mode action.
- Toggle mode: a fresh make (held=0) inverts mode. brk has no effect on mode.
- Momentary mode: a fresh make sets mode=1; brk sets mode=0. Repeats keep mode=1.
- One-shot mode: a fresh make with mode=0 arms (mode=1); a fresh make with mode=1 disarms (double press cancels). consume with mode=1 and held=0 clears mode. While held=1, consume does not clear (key held down acts as momentary). A brk after consume occurred during the hold clears mode; a brk with no consume during the hold leaves mode armed. One extra per-channel "used" flag records consume-while-held and is cleared on the next fresh make.
- make and brk in the same cycle on a channel: evaluate make first, then brk. Toggle: inverts if held was 0, held ends 0. Momentary: mode ends 0, no change pulse if it started at 0. One-shot: arms or disarms as for make, held ends 0.
- consume and a fresh make in the same cycle on a one-shot channel: make wins, consume is ignored for that channel.
- clear: mode_out <= RESET_STATE, held <= 0, used <= 0. Overrides make/brk/consume in the same cycle. change pulses are raised for bits that actually changed.

## Timing
- Reset (rst=1, asynchronous): mode_out=RESET_STATE, held=0, change=0, any_change=0, used=0. The first edge after deassertion is a normal evaluation edge.
- Latency: an event sampled at edge k is visible on mode_out/held after edge k. change is registered alongside mode_out and is high for exactly the cycle after edge k.
- Back-to-back events on consecutive cycles are each processed. There is no hold-off.
- rst asserted mid-hold: all state is discarded. A subsequent brk with held=0 is ignored. Momentary mode stays 0.
- brk while held=0 (lost make): no state change.

## Test plan
- Reset then toggle: N_CH=3, ch0 toggle; make[0] pulse -> mode_out=3'b001, change=3'b001 for 1 cycle. Second make after brk -> mode_out=3'b000.
- Typematic: ch0 toggle; make[0] ×5 at 10-cycle intervals, then brk[0] -> mode_out[0]=1 throughout, single change pulse, held[0] 1 until the brk edge.
- Momentary: ch1 MODE=01; make[1] -> mode_out[1]=1; brk[1] -> 0; make and brk in the same cycle -> mode_out[1] stays 0, no change pulse.
- One-shot: ch2 MODE=10; make, brk, then consume -> mode_out[2] goes 1 then 0 one cycle after consume. Make, consume while held, brk -> cleared on the brk edge. Make, brk, make -> disarmed.
- Clear priority: RESET_STATE=3'b100, all channels set; clear asserted in the same cycle as make[0] -> mode_out=3'b100, held=0, change marks only the changed bits.
- Async reset mid-operation: held[1]=1, mode_out=3'b011; pulse rst between edges -> outputs at reset values immediately; following brk[1] -> no change.

Source files
------------

// File: rtl/kbd_lock_fsm_if.sv
// Modifier/lock channel bus: per-channel key events in, per-channel modifier state out.
interface kbd_lock_fsm_if #(
    parameter int unsigned N_CH = 3
);
    logic [N_CH-1:0] make;
    logic [N_CH-1:0] brk;
    logic            consume;
    logic            clear;
    logic [N_CH-1:0] mode_out;
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] change;
    logic            any_change;

    modport master (
        output make, brk, consume, clear,
        input  mode_out, held, change, any_change
    );

    modport slave (
        input  make, brk, consume, clear,
        output mode_out, held, change, any_change
    );
endinterface

// File: rtl/kbd_lock_fsm.sv
// Per-channel keyboard modifier state (toggle / momentary / one-shot) with typematic
// suppression and registered one-cycle change pulses.
module kbd_lock_fsm #(
    parameter int unsigned         N_CH        = 3,
    parameter logic [2*N_CH-1:0]   MODE_VEC    = '0,
    parameter logic [N_CH-1:0]     RESET_STATE = '0
) (
    input logic           clk,
    input logic           rst,
    kbd_lock_fsm_if.slave bus
);
    typedef enum logic [1:0] {
        ModeToggle    = 2'b00,
        ModeMomentary = 2'b01,
        ModeOneShot   = 2'b10,
        ModeToggleAlt = 2'b11
    } ch_mode_e;

    logic [N_CH-1:0] mode_q, mode_d;
    logic [N_CH-1:0] held_q, held_d;
    logic [N_CH-1:0] used_q, used_d;
    logic [N_CH-1:0] change_q;
    logic            any_change_q;
    logic [N_CH-1:0] fresh;
    logic [N_CH-1:0] brk_eff;

    // A make while already held is typematic repeat; a brk without a live hold is stale.
    assign fresh   = bus.make & ~held_q;
    assign brk_eff = bus.brk & (held_q | bus.make);

    always_comb begin
        mode_d = mode_q;
        held_d = held_q;
        used_d = used_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            unique case (ch_mode_e'(MODE_VEC[2*i +: 2]))
                ModeMomentary: begin
                    if (bus.make[i]) mode_d[i] = 1'b1;
                    if (brk_eff[i])  mode_d[i] = 1'b0;
                end
                ModeOneShot: begin
                    if (fresh[i]) begin
                        mode_d[i] = ~mode_q[i];
                        used_d[i] = 1'b0;
                    end else if (bus.consume) begin
                        // Consume during a hold is remembered and acted on at release.
                        if (held_q[i])      used_d[i] = 1'b1;
                        else if (mode_q[i]) mode_d[i] = 1'b0;
                    end
                    if (brk_eff[i] && used_d[i]) mode_d[i] = 1'b0;
                end
                ModeToggle, ModeToggleAlt: begin
                    if (fresh[i]) mode_d[i] = ~mode_q[i];
                end
                default: ;
            endcase
            if (bus.make[i]) held_d[i] = 1'b1;
            if (brk_eff[i])  held_d[i] = 1'b0;
        end
        if (bus.clear) begin
            mode_d = RESET_STATE;
            held_d = '0;
            used_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= RESET_STATE;
            held_q       <= '0;
            used_q       <= '0;
            change_q     <= '0;
            any_change_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            held_q       <= held_d;
            used_q       <= used_d;
            change_q     <= mode_d ^ mode_q;
            any_change_q <= |(mode_d ^ mode_q);
        end
    end

    assign bus.mode_out   = mode_q;
    assign bus.held       = held_q;
    assign bus.change     = change_q;
    assign bus.any_change = any_change_q;
endmodule

// File: tb/tb_kbd_lock_fsm.sv
// Bench for kbd_lock_fsm: event-ordered reference model, per-cycle compare, directed pins.
module tb_kbd_lock_fsm;
    localparam int unsigned   N  = 4;
    localparam logic [2*N-1:0] MV = 8'b11_10_01_00;
    localparam logic [N-1:0]  RS = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b0;

    kbd_lock_fsm_if #(.N_CH(N)) bus ();

    kbd_lock_fsm #(
        .N_CH       (N),
        .MODE_VEC   (MV),
        .RESET_STATE(RS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    logic [N-1:0] m_mode, m_held, m_used, m_change;
    logic         m_any;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply make, then consume, then brk, as discrete key events per channel.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode   <= RS;
            m_held   <= '0;
            m_used   <= '0;
            m_change <= '0;
            m_any    <= 1'b0;
        end else begin
            logic [N-1:0] nm, nh, nu;
            nm = m_mode;
            nh = m_held;
            nu = m_used;
            for (int i = 0; i < int'(N); i++) begin
                int   kind;
                logic press;
                kind  = int'((MV >> (2 * i)) & 8'd3);
                press = bus.make[i] && !nh[i];
                if (bus.clear) begin
                    nm[i] = RS[i];
                    nh[i] = 1'b0;
                    nu[i] = 1'b0;
                end else begin
                    if (press) begin
                        if (kind == 1) nm[i] = 1'b1;
                        else           nm[i] = !nm[i];
                        if (kind == 2) nu[i] = 1'b0;
                    end
                    if (bus.make[i]) nh[i] = 1'b1;
                    if (kind == 2 && bus.consume && !press) begin
                        if (nh[i])      nu[i] = 1'b1;
                        else if (nm[i]) nm[i] = 1'b0;
                    end
                    if (bus.brk[i] && nh[i]) begin
                        nh[i] = 1'b0;
                        if (kind == 1)          nm[i] = 1'b0;
                        if (kind == 2 && nu[i]) nm[i] = 1'b0;
                    end
                end
            end
            m_change <= nm ^ m_mode;
            m_any    <= |(nm ^ m_mode);
            m_mode   <= nm;
            m_held   <= nh;
            m_used   <= nu;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc mode_out", 32'(bus.mode_out), 32'(m_mode));
            chk("cyc held", 32'(bus.held), 32'(m_held));
            chk("cyc change", 32'(bus.change), 32'(m_change));
            chk("cyc any_change", 32'(bus.any_change), 32'(m_any));
        end
    end

    task automatic step(input logic [N-1:0] mk, input logic [N-1:0] bk,
                        input logic cs, input logic cl);
        bus.make    = mk;
        bus.brk     = bk;
        bus.consume = cs;
        bus.clear   = cl;
        @(posedge clk);
        #1;
        bus.make    = '0;
        bus.brk     = '0;
        bus.consume = 1'b0;
        bus.clear   = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [N-1:0] mode,
                                input logic [N-1:0] held, input logic [N-1:0] change);
        chk({tag, " mode_out"}, 32'(bus.mode_out), 32'(mode));
        chk({tag, " held"}, 32'(bus.held), 32'(held));
        chk({tag, " change"}, 32'(bus.change), 32'(change));
        chk({tag, " any_change"}, 32'(bus.any_change), 32'(|change));
    endtask

    initial begin
        logic [N-1:0] mk, bk;
        bus.make    = '0;
        bus.brk     = '0;
        bus.consume = 1'b0;
        bus.clear   = 1'b0;
        #2 rst = 1'b1;
        checking = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        expect_state("reset", 4'b0100, 4'b0000, 4'b0000);

        // Toggle channel 0
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        expect_state("tog_make", 4'b0101, 4'b0001, 4'b0001);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_state("tog_idle", 4'b0101, 4'b0001, 4'b0000);
        step(4'b0000, 4'b0001, 1'b0, 1'b0);
        expect_state("tog_brk", 4'b0101, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        expect_state("tog_make2", 4'b0100, 4'b0001, 4'b0001);
        step(4'b0000, 4'b0001, 1'b0, 1'b0);

        // Typematic repeats on channel 0
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            repeat (9) step(4'b0000, 4'b0000, 1'b0, 1'b0);
            step(4'b0001, 4'b0000, 1'b0, 1'b0);
            expect_state("typ_repeat", 4'b0101, 4'b0001, 4'b0000);
        end
        step(4'b0000, 4'b0001, 1'b0, 1'b0);
        expect_state("typ_brk", 4'b0101, 4'b0000, 4'b0000);

        // Momentary channel 1
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        expect_state("mom_make", 4'b0111, 4'b0010, 4'b0010);
        step(4'b0000, 4'b0010, 1'b0, 1'b0);
        expect_state("mom_brk", 4'b0101, 4'b0000, 4'b0010);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        expect_state("mom_same_cycle", 4'b0101, 4'b0000, 4'b0000);

        // One-shot channel 2 (armed out of reset)
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        expect_state("os_consume_rs", 4'b0001, 4'b0000, 4'b0100);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        expect_state("os_arm", 4'b0101, 4'b0100, 4'b0100);
        step(4'b0000, 4'b0100, 1'b0, 1'b0);
        expect_state("os_brk_armed", 4'b0101, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        expect_state("os_consume", 4'b0001, 4'b0000, 4'b0100);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        expect_state("os_held_consume", 4'b0101, 4'b0100, 4'b0000);
        step(4'b0000, 4'b0100, 1'b0, 1'b0);
        expect_state("os_brk_used", 4'b0001, 4'b0000, 4'b0100);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0100, 1'b0, 1'b0);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        expect_state("os_disarm", 4'b0001, 4'b0100, 4'b0100);
        step(4'b0000, 4'b0100, 1'b0, 1'b0);

        // Mode code 11 on channel 3 behaves as toggle
        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        expect_state("alt_toggle", 4'b1001, 4'b1000, 4'b1000);
        step(4'b0000, 4'b1000, 1'b0, 1'b0);

        // Clear overrides a same-cycle make
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        expect_state("pre_clear", 4'b1111, 4'b0110, 4'b0100);
        step(4'b0001, 4'b0000, 1'b0, 1'b1);
        expect_state("clear", 4'b0100, 4'b0000, 4'b1011);

        // Asynchronous reset between edges, then a stale brk
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        expect_state("pre_rst", 4'b0111, 4'b0011, 4'b0011);
        #1 rst = 1'b1;
        #1 expect_state("async_rst", 4'b0100, 4'b0000, 4'b0000);
        rst = 1'b0;
        step(4'b0000, 4'b0010, 1'b0, 1'b0);
        expect_state("post_rst_brk", 4'b0100, 4'b0000, 4'b0000);

        // Randomized traffic against the model
        repeat (800) begin
            if ($urandom_range(99) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            for (int i = 0; i < int'(N); i++) begin
                mk[i] = ($urandom_range(3) == 0);
                bk[i] = ($urandom_range(3) == 0);
            end
            step(mk, bk, ($urandom_range(5) == 0), ($urandom_range(63) == 0));
        end
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
